filter_div: RTL and testbench
=============================

FILTER_DIV -- requirements
Module: filter_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operands valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-005 SHALL have port dividend, input, 72 bits: signed two's-complement numerator, same width as a 36x36 filter product.
REQ-006 SHALL have port divisor, input, 36 bits: signed two's-complement denominator.
REQ-007 SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts result.
REQ-009 SHALL have port quotient, output, 36 bits: signed quotient.
REQ-010 SHALL have port remainder, output, 36 bits: signed remainder.
REQ-011 SHALL have port dbz, output, 1 bit: divide-by-zero flag, qualified by out_valid.
REQ-012 SHALL have port ovf, output, 1 bit: quotient overflow flag, qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, ITER, FIX, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept operands on the edge where in_valid&in_ready=1, register them, and move IDLE->CHECK; in_valid without in_ready is ignored.
REQ-016 SHALL, in CHECK, form unsigned magnitudes |dividend| (72 bits) and |divisor| (36 bits), record result sign = dividend[71]^divisor[35] and remainder sign = dividend[71].
REQ-017 SHALL, in CHECK, set dbz when divisor==0 and go CHECK->DONE.
REQ-018 SHALL, in CHECK with divisor!=0, set ovf when |dividend|[71:35] >= |divisor| (quotient magnitude >= 2^35, including exact -2^35) and go CHECK->DONE.
REQ-019 SHALL otherwise go CHECK->ITER and load the 6-bit iteration counter with 35.
REQ-020 SHALL, in ITER, perform one restoring shift-subtract step per cycle on the 72-bit magnitude (shift left 1, trial-subtract |divisor| from the upper 37 bits, keep result and shift in 1 if non-negative, else shift in 0), exactly 36 steps, leaving ITER after counter reaches 0.
REQ-021 SHALL, in FIX, negate quotient magnitude if result sign=1 and negate remainder magnitude if remainder sign=1, then go FIX->DONE.
REQ-022 SHALL truncate toward zero: dividend = quotient*divisor + remainder, |remainder| < |divisor|, remainder zero or same sign as dividend.
REQ-023 SHALL set out_valid 39 cycles after the accept edge for normal division (CHECK 1, ITER 36, FIX 1, then DONE), and 2 cycles after it for dbz/ovf.
REQ-024 SHALL, on dbz, output quotient 36'h7FFFFFFFF if dividend>=0 else 36'h800000000, remainder 0, ovf=0.
REQ-025 SHALL, on ovf, output quotient 36'h7FFFFFFFF if result sign=0 else 36'h800000000, remainder 0, dbz=0.
REQ-026 SHALL hold quotient, remainder, dbz, ovf, out_valid stable in DONE until out_valid&out_ready, then go DONE->IDLE.
REQ-027 SHALL keep in_ready=0 in the output-handshake cycle; earliest next accept is the cycle after returning to IDLE.
REQ-028 SHALL keep the last result on quotient/remainder/dbz/ovf while not in DONE (don't-care to consumers, but not toggling during ITER).
REQ-029 SHALL ignore in_valid and operand changes in every state other than IDLE.
REQ-030 SHALL handle dividend = -2^71 and divisor = -2^35 magnitudes without loss (72- and 36-bit unsigned magnitudes).

Reset
REQ-031 SHALL, while reset_n=0, force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0, ovf=0, counter=0, independent of clk.
REQ-032 SHALL, on reset asserted mid-operation (any state), abort without producing a result; first accept possible on the first rising edge after reset_n deasserts.

Verification
REQ-033 SHALL cover: dividend=100, divisor=7 -> quotient=14, remainder=2, dbz=ovf=0, out_valid 39 cycles after accept.
REQ-034 SHALL cover: sign combinations -100/7 -> -14,-2; 100/-7 -> -14,2; -100/-7 -> 14,-2.
REQ-035 SHALL cover: divisor=0 with dividend=-5 -> dbz=1, quotient=36'h800000000, remainder=0, out_valid 2 cycles after accept.
REQ-036 SHALL cover: dividend=2^40, divisor=1 -> ovf=1, quotient=36'h7FFFFFFFF, remainder=0; and dividend=-2^35, divisor=1 -> ovf=1, quotient=36'h800000000.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: reset_n pulsed low at ITER step 20 -> all outputs at reset values immediately, no out_valid; next operation 1000/10 -> 100, 0.

Source files
------------

// File: rtl/filter_div.sv
// filter_div: signed 72/36 restoring divider with divide-by-zero and overflow saturation.
// Rev 1.0 -- initial release.
`default_nettype none

module filter_div (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [71:0] dividend,
   input  logic [35:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [35:0] quotient,
   output logic [35:0] remainder,
   output logic        dbz,
   output logic        ovf
);

   localparam logic [35:0] Q_MAX = 36'h7FFFFFFFF;
   localparam logic [35:0] Q_MIN = 36'h800000000;

   typedef enum logic [2:0] {IDLE, CHECK, ITER, FIX, DONE} state_t;

   state_t      state_q, state_d;
   logic [71:0] work_q, work_d;
   logic [35:0] dvs_q, dvs_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [35:0] quo_q, quo_d;
   logic [35:0] rem_q, rem_d;
   logic        dbz_q, dbz_d;
   logic        ovf_q, ovf_d;

   logic [71:0] dvd_mag;
   logic [35:0] dvs_mag;
   logic [36:0] trial;

   // In CHECK, work_q/dvs_q still hold the raw signed operands.
   assign dvd_mag = work_q[71] ? (~work_q + 72'd1) : work_q;
   assign dvs_mag = dvs_q[35]  ? (~dvs_q + 36'd1)  : dvs_q;
   assign trial   = work_q[71:35] - {1'b0, dvs_q};

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;
   assign ovf       = ovf_q;

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = dividend;
               dvs_d   = divisor;
               state_d = CHECK;
            end
         end
         CHECK: begin
            qneg_d = work_q[71] ^ dvs_q[35];
            rneg_d = work_q[71];
            work_d = dvd_mag;
            dvs_d  = dvs_mag;
            if (dvs_q == 36'd0) begin
               dbz_d   = 1'b1;
               ovf_d   = 1'b0;
               quo_d   = work_q[71] ? Q_MIN : Q_MAX;
               rem_d   = 36'd0;
               state_d = DONE;
            end else if (dvd_mag[71:35] >= {1'b0, dvs_mag}) begin
               dbz_d   = 1'b0;
               ovf_d   = 1'b1;
               quo_d   = (work_q[71] ^ dvs_q[35]) ? Q_MIN : Q_MAX;
               rem_d   = 36'd0;
               state_d = DONE;
            end else begin
               cnt_d   = 6'd35;
               state_d = ITER;
            end
         end
         ITER: begin
            // Upper 36 bits accumulate the partial remainder, lower bits collect quotient bits.
            if (!trial[36])
               work_d = {trial[35:0], work_q[34:0], 1'b1};
            else
               work_d = {work_q[70:0], 1'b0};
            if (cnt_q == 6'd0)
               state_d = FIX;
            else
               cnt_d = cnt_q - 6'd1;
         end
         FIX: begin
            quo_d   = qneg_q ? (~work_q[35:0] + 36'd1)  : work_q[35:0];
            rem_d   = rneg_q ? (~work_q[71:36] + 36'd1) : work_q[71:36];
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         work_q  <= 72'd0;
         dvs_q   <= 36'd0;
         cnt_q   <= 6'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quo_q   <= 36'd0;
         rem_q   <= 36'd0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_filter_div.sv
// tb_filter_div: directed vectors for filter_div checked against an arithmetic reference model.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_filter_div;

   localparam logic [35:0] Q_MAX = 36'h7FFFFFFFF;
   localparam logic [35:0] Q_MIN = 36'h800000000;
   localparam logic signed [71:0] LIM = 72'sd34359738368;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] dividend;
   logic [35:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] quotient;
   logic [35:0] remainder;
   logic        dbz;
   logic        ovf;

   filter_div dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [35:0] exp_q, exp_r, last_q, last_r;
   logic        exp_z, exp_o, last_z, last_o;

   typedef struct {
      logic [71:0] a;
      logic [35:0] b;
      logic [35:0] q;
      logic [35:0] r;
      logic        z;
      logic        o;
      int          lat;
   } vec_t;
   vec_t vq[$];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: language-level truncating division plus saturation rules.
   function automatic void model(input logic signed [71:0] a, input logic signed [35:0] b,
                                 output logic [35:0] q, output logic [35:0] r,
                                 output logic z, output logic o);
      logic signed [71:0] bb, qf, rf;
      bb = b;
      z = 1'b0;
      o = 1'b0;
      if (b == 36'sd0) begin
         z = 1'b1;
         q = (a < 0) ? Q_MIN : Q_MAX;
         r = 36'd0;
      end else begin
         qf = a / bb;
         rf = a % bb;
         if (qf >= LIM || qf <= -LIM) begin
            o = 1'b1;
            q = (a[71] ^ b[35]) ? Q_MIN : Q_MAX;
            r = 36'd0;
         end else begin
            q = qf[35:0];
            r = rf[35:0];
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("reset_outputs", {in_ready, out_valid, quotient, remainder, dbz, ovf},
             {1'b1, 1'b0, 36'd0, 36'd0, 1'b0, 1'b0});
         last_q = 36'd0; last_r = 36'd0; last_z = 1'b0; last_o = 1'b0;
      end else if (out_valid) begin
         chk("result", {quotient, remainder, dbz, ovf}, {exp_q, exp_r, exp_z, exp_o});
         last_q = exp_q; last_r = exp_r; last_z = exp_z; last_o = exp_o;
      end else begin
         chk("held_result", {quotient, remainder, dbz, ovf}, {last_q, last_r, last_z, last_o});
      end
   end

   task automatic drive_op(input logic [71:0] a, input logic [35:0] b);
      logic [35:0] q, r;
      logic        z, o;
      model($signed(a), $signed(b), q, r, z, o);
      exp_q = q; exp_r = r; exp_z = z; exp_o = o;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
   endtask

   task automatic finish_op(input int lat_exp, input bit stall);
      int cyc;
      chk("in_ready_before_accept", {79'd0, in_ready}, 80'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency", 80'(cyc), 80'(lat_exp));
      if (stall) begin
         in_valid = 1'b1;
         dividend = 72'd999;
         divisor  = 36'd3;
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_hold", {78'd0, out_valid, in_ready}, {78'd0, 2'b10});
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("handshake_to_idle", {78'd0, out_valid, in_ready}, {78'd0, 2'b01});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [35:0] mq, mr;
      logic        mz, mo;
      int          cyc;

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      dividend = 72'd0; divisor = 36'd0;
      exp_q = 36'd0; exp_r = 36'd0; exp_z = 1'b0; exp_o = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      reset_n = 1'b1;

      vq.push_back('{72'd100,               36'd7,           36'd14,          36'd2,           1'b0, 1'b0, 39});
      vq.push_back('{-72'sd100,             36'd7,           36'hFFFFFFFF2,   36'hFFFFFFFFE,   1'b0, 1'b0, 39});
      vq.push_back('{72'd100,               -36'sd7,         36'hFFFFFFFF2,   36'd2,           1'b0, 1'b0, 39});
      vq.push_back('{-72'sd100,             -36'sd7,         36'd14,          36'hFFFFFFFFE,   1'b0, 1'b0, 39});
      vq.push_back('{-72'sd5,               36'd0,           Q_MIN,           36'd0,           1'b1, 1'b0, 2});
      vq.push_back('{72'd5,                 36'd0,           Q_MAX,           36'd0,           1'b1, 1'b0, 2});
      vq.push_back('{72'h100_0000_0000,     36'd1,           Q_MAX,           36'd0,           1'b0, 1'b1, 2});
      vq.push_back('{-72'sd34359738368,     36'd1,           Q_MIN,           36'd0,           1'b0, 1'b1, 2});
      vq.push_back('{72'd240518168575,      36'd7,           Q_MAX,           36'd6,           1'b0, 1'b0, 39});
      vq.push_back('{72'd240518168576,      36'd7,           Q_MAX,           36'd0,           1'b0, 1'b1, 2});
      vq.push_back('{-72'sd240518168576,    36'd7,           Q_MIN,           36'd0,           1'b0, 1'b1, 2});
      vq.push_back('{72'h80_0000_0000_0000_0000, -36'sd1,    Q_MAX,           36'd0,           1'b0, 1'b1, 2});
      vq.push_back('{72'h20_0000_0000_0000_0005, 36'h800000000, 36'hC00000000, 36'd5,          1'b0, 1'b0, 39});
      vq.push_back('{72'd0,                 36'd5,           36'd0,           36'd0,           1'b0, 1'b0, 39});
      vq.push_back('{-72'sd1,               36'd5,           36'd0,           36'hFFFFFFFFF,   1'b0, 1'b0, 39});

      foreach (vq[i]) begin
         model($signed(vq[i].a), $signed(vq[i].b), mq, mr, mz, mo);
         chk("model_literal", {mq, mr, mz, mo, 6'd0}, {vq[i].q, vq[i].r, vq[i].z, vq[i].o, 6'd0});
         @(posedge clk); #2;
         drive_op(vq[i].a, vq[i].b);
         finish_op(vq[i].lat, 1'b0);
      end

      // Consumer stalls for 10 cycles while upstream offers a new operand.
      @(posedge clk); #2;
      out_ready = 1'b0;
      drive_op(72'd100, 36'd7);
      finish_op(39, 1'b1);

      // Abort mid-iteration with an asynchronous reset.
      @(posedge clk); #2;
      drive_op(72'd12345, 36'd11);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      repeat (20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("busy_before_abort", {78'd0, out_valid, in_ready}, {78'd0, 2'b00});
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_immediate", {in_ready, out_valid, quotient, remainder, dbz, ovf},
          {1'b1, 1'b0, 36'd0, 36'd0, 1'b0, 1'b0});
      repeat (3) @(posedge clk);
      #2;
      drive_op(72'd1000, 36'd10);
      chk("post_reset_model", {exp_q, exp_r, exp_z, exp_o, 6'd0}, {36'd100, 36'd0, 1'b0, 1'b0, 6'd0});
      @(negedge clk); #1;
      reset_n = 1'b1;
      finish_op(39, 1'b0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
